// File: rtl/dcs_udp_cmd_decoder_pkg.sv
// Shared types and constants for the DCS UDP command decoder.
// Holds FSM encodings, header byte offsets and the 65-bit command entry layout.
package dcs_udp_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_DROP = 3'd5
  } state_e;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned CMD_BYTES     = 8;
  localparam int unsigned STAT_W        = 16;
  localparam int unsigned REM_W         = 13;

  // Header byte offsets (byte 0 is consumed in IDLE)
  localparam logic [2:0] HDR_DST_HI = 3'd2;
  localparam logic [2:0] HDR_DST_LO = 3'd3;
  localparam logic [2:0] HDR_LEN_HI = 3'd4;
  localparam logic [2:0] HDR_LEN_LO = 3'd5;
  localparam logic [2:0] HDR_LAST   = 3'd7;

  typedef struct packed {
    logic        last;
    logic        rnw;
    logic [30:0] addr;
    logic [31:0] wdata;
  } cmd_entry_t;

  localparam int unsigned CMD_ENTRY_W = $bits(cmd_entry_t);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dcs_cmd_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is presented while not empty.
// A pop in the same cycle frees a slot for a push into a full FIFO.
module dcs_cmd_sync_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Zero the head while empty so outputs read 0 after reset
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dcs_udp_cmd_decoder.sv
// UDP datagram -> 8-byte register command decoder with FWFT command queue.
// Optional DCS_CMD_PORT_FILTER_EN: drop foreign dst_port traffic silently.
module dcs_udp_cmd_decoder
  import dcs_udp_cmd_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] LISTEN_PORT = 16'h1001
) (
  input  logic              udp_rx_clk,
  input  logic              reset,
  input  logic [7:0]        udp_rxd,
  input  logic              udp_rx_dv,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rnw,
  output logic [30:0]       cmd_addr,
  output logic [31:0]       cmd_wdata,
  output logic              cmd_last,
  output logic [STAT_W-1:0] stat_frames,
  output logic [STAT_W-1:0] stat_drops,
  output logic [STAT_W-1:0] stat_ovf
);

  state_e           state_q;
  state_e           state_d;
  logic             dv_q;
  logic [2:0]       byte_cnt;
  logic [15:0]      dst_port;
  logic [15:0]      udp_len;
  logic [REM_W-1:0] rem_cmds;
  logic [23:0]      word_sr;
  logic [31:0]      addr_word;
  logic             push_c;
  logic             frame_c;
  logic             drop_c;
  logic             pop_c;
  logic             port_ok;
  logic             len_ok;
  logic             fifo_full;
  logic             fifo_empty;
  cmd_entry_t       push_entry;
  cmd_entry_t       head;

`ifdef DCS_CMD_PORT_FILTER_EN
  assign port_ok = (dst_port == LISTEN_PORT);
`else
  logic unused_port_cfg;
  assign port_ok         = 1'b1;
  assign unused_port_cfg = ^{dst_port, LISTEN_PORT};
`endif

  assign len_ok = (udp_len >= 16'(UDP_HDR_BYTES + CMD_BYTES)) && (udp_len[2:0] == 3'd0);

  // State register
  always_ff @(posedge udp_rx_clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Previous-cycle dv: a burst already in flight at reset release is never re-parsed
  always_ff @(posedge udp_rx_clk) begin
    dv_q <= udp_rx_dv;
  end

  // Next-state and per-byte strobes
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    frame_c = 1'b0;
    drop_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (udp_rx_dv && !dv_q) state_d = ST_HDR;
      ST_HDR: begin
        if (!udp_rx_dv) begin
          state_d = ST_IDLE;
          drop_c  = 1'b1;
        end else if (byte_cnt == HDR_LAST) begin
          if (!port_ok) begin
            state_d = ST_DROP;
          end else if (!len_ok) begin
            state_d = ST_DROP;
            drop_c  = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (!udp_rx_dv) begin
          state_d = ST_IDLE;
          drop_c  = 1'b1;
        end else if (byte_cnt[1:0] == 2'd3) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!udp_rx_dv) begin
          state_d = ST_IDLE;
          drop_c  = 1'b1;
        end else if (byte_cnt[1:0] == 2'd3) begin
          push_c = 1'b1;
          if (rem_cmds == REM_W'(1)) begin
            state_d = ST_PAD;
            frame_c = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_PAD:  if (!udp_rx_dv) state_d = ST_IDLE;
      ST_DROP: if (!udp_rx_dv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign push_entry.last  = (rem_cmds == REM_W'(1));
  assign push_entry.rnw   = addr_word[31];
  assign push_entry.addr  = addr_word[30:0];
  assign push_entry.wdata = {word_sr, udp_rxd};

  // Byte counter runs 1..7 through the header, then wraps mod 4 per command word
  always_ff @(posedge udp_rx_clk) begin
    if (reset) begin
      byte_cnt  <= '0;
      dst_port  <= '0;
      udp_len   <= '0;
      rem_cmds  <= '0;
      word_sr   <= '0;
      addr_word <= '0;
    end else begin
      if (state_q == ST_IDLE)  byte_cnt <= 3'd1;
      else if (udp_rx_dv)      byte_cnt <= byte_cnt + 3'd1;

      if (state_q == ST_HDR && udp_rx_dv) begin
        case (byte_cnt)
          HDR_DST_HI: dst_port[15:8] <= udp_rxd;
          HDR_DST_LO: dst_port[7:0]  <= udp_rxd;
          HDR_LEN_HI: udp_len[15:8]  <= udp_rxd;
          HDR_LEN_LO: udp_len[7:0]   <= udp_rxd;
          HDR_LAST:   rem_cmds       <= udp_len[15:3] - REM_W'(1);
          default: ;
        endcase
      end

      if ((state_q == ST_ADDR || state_q == ST_DATA) && udp_rx_dv) begin
        word_sr <= {word_sr[15:0], udp_rxd};
      end
      if (state_q == ST_ADDR && udp_rx_dv && byte_cnt[1:0] == 2'd3) begin
        addr_word <= {word_sr, udp_rxd};
      end
      if (push_c) rem_cmds <= rem_cmds - REM_W'(1);
    end
  end

  // Saturating statistics
  always_ff @(posedge udp_rx_clk) begin
    if (reset) begin
      stat_frames <= '0;
      stat_drops  <= '0;
      stat_ovf    <= '0;
    end else begin
      if (frame_c) stat_frames <= sat_inc(stat_frames);
      if (drop_c)  stat_drops  <= sat_inc(stat_drops);
      if (push_c && fifo_full && !pop_c) stat_ovf <= sat_inc(stat_ovf);
    end
  end

  assign pop_c = !fifo_empty && cmd_ready;

  dcs_cmd_sync_fifo #(
    .WIDTH (CMD_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (udp_rx_clk),
    .reset   (reset),
    .wr_en   (push_c),
    .wr_data (push_entry),
    .rd_en   (pop_c),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;
  assign cmd_last  = head.last;
  assign cmd_rnw   = head.rnw;
  assign cmd_addr  = head.addr;
  assign cmd_wdata = head.wdata;

endmodule

// File: tb/tb_dcs_udp_cmd_decoder.sv
// Self-checking bench for dcs_udp_cmd_decoder: datagram table plus hand-written corner cases.
// Expected commands go to a queue as payload is driven and are compared as the consumer pops.
`timescale 1ns/1ps
module tb_dcs_udp_cmd_decoder;
  import dcs_udp_cmd_decoder_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  udp_rxd;
  logic        udp_rx_dv;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rnw;
  logic [30:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_last;
  logic [15:0] stat_frames;
  logic [15:0] stat_drops;
  logic [15:0] stat_ovf;

  typedef struct {
    int unsigned hdr_bytes;
    logic [15:0] udp_len;
    logic [15:0] dst;
    int unsigned pay_bytes;
    int unsigned pad;
    int unsigned exp_cmds;
    bit          exp_last;
    bit          exp_frame;
    bit          exp_drop;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] pay_w [16];
  cmd_entry_t  sbq [$];
  int          checks = 0;
  int          errors = 0;
  int          exp_frames = 0;
  int          exp_drops  = 0;
  int          exp_ovf    = 0;

  always #5 clk = ~clk;

  dcs_udp_cmd_decoder #(
    .FIFO_DEPTH  (DEPTH),
    .LISTEN_PORT (16'h1001)
  ) dut (
    .udp_rx_clk  (clk),
    .reset       (reset),
    .udp_rxd     (udp_rxd),
    .udp_rx_dv   (udp_rx_dv),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rnw     (cmd_rnw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_last    (cmd_last),
    .stat_frames (stat_frames),
    .stat_drops  (stat_drops),
    .stat_ovf    (stat_ovf)
  );

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sample at negedge, then let the posedge consume inputs and any pop
  task automatic cycle();
    cmd_entry_t e;
    @(negedge clk);
    if (cmd_valid && cmd_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got %0h expected none",
                 {cmd_last, cmd_rnw, cmd_addr, cmd_wdata});
      end else begin
        e = sbq.pop_front();
        chk("cmd_pop", {cmd_last, cmd_rnw, cmd_addr, cmd_wdata}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b);
    udp_rx_dv = 1'b1;
    udp_rxd   = b;
    cycle();
  endtask

  task automatic send(input vec_t v, input bit lat_chk);
    logic [7:0] hdr [8];
    logic [31:0] w;
    cmd_entry_t e;
    int k;
    hdr = '{8'h12, 8'h34, v.dst[15:8], v.dst[7:0], v.udp_len[15:8], v.udp_len[7:0], 8'h00, 8'h00};
    for (int i = 0; i < int'(v.hdr_bytes); i++) drive(hdr[i]);
    if (v.hdr_bytes == 8) begin
      for (int i = 0; i < int'(v.pay_bytes); i++) begin
        k = i / 8;
        if ((i % 8 == 0) && (k < int'(v.exp_cmds))) begin
          e.last  = v.exp_last && (k == int'(v.exp_cmds) - 1);
          e.rnw   = pay_w[2*k][31];
          e.addr  = pay_w[2*k][30:0];
          e.wdata = pay_w[2*k+1];
          sbq.push_back(e);
        end
        w = pay_w[i/4];
        if (lat_chk && i == 7) chk("latency_pre", 65'(cmd_valid), 65'(0));
        drive(w[8*(3-(i%4)) +: 8]);
        if (lat_chk && i == 7) chk("latency_post", 65'(cmd_valid), 65'(1));
      end
      for (int i = 0; i < int'(v.pad); i++) drive(8'($urandom));
    end
    udp_rx_dv = 1'b0;
    udp_rxd   = 8'h00;
    cycle();
    cycle();
  endtask

  task automatic drain();
    int n = 0;
    cmd_ready = 1'b1;
    while ((sbq.size() != 0 || cmd_valid) && n < 64) begin
      cycle();
      n++;
    end
    chk("drain_sb_empty", 65'(sbq.size()), 65'(0));
    chk("drain_valid_low", 65'(cmd_valid), 65'(0));
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_frames"}, 65'(stat_frames), 65'(exp_frames));
    chk({tag, "_drops"},  65'(stat_drops),  65'(exp_drops));
    chk({tag, "_ovf"},    65'(stat_ovf),    65'(exp_ovf));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) pay_w[i] = $urandom;
  endtask

  task automatic account(input vec_t v);
    if (v.exp_frame) exp_frames++;
    if (v.exp_drop)  exp_drops++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    cmd_entry_t h;
    //         hdr len     dst       pay pad cmds last frm drp
    vecs[0] = '{8, 16'd24, 16'h1001, 16, 0,  2,   1,   1,  0};
    vecs[1] = '{8, 16'd20, 16'h1001, 12, 0,  0,   0,   0,  1};
    vecs[2] = '{8, 16'd16, 16'h1001, 8,  10, 1,   1,   1,  0};
    vecs[3] = '{8, 16'd24, 16'h1001, 12, 0,  1,   0,   0,  1};
    vecs[4] = '{8, 16'd8,  16'h1001, 0,  4,  0,   0,   0,  1};
    vecs[5] = '{8, 16'd40, 16'h1001, 32, 0,  4,   1,   1,  0};
    vecs[6] = '{5, 16'd24, 16'h1001, 0,  0,  0,   0,   0,  1};
    vecs[7] = '{8, 16'd16, 16'h1001, 3,  0,  0,   0,   0,  1};
    vecs[8] = '{8, 16'd17, 16'h1001, 9,  0,  0,   0,   0,  1};
    vecs[9] = '{8, 16'd32, 16'h1001, 24, 6,  3,   1,   1,  0};

    reset     = 1'b1;
    udp_rx_dv = 1'b0;
    udp_rxd   = 8'h00;
    cmd_ready = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    chk("rst_valid", 65'(cmd_valid), 65'(0));
    chk("rst_last",  65'(cmd_last),  65'(0));
    chk("rst_rnw",   65'(cmd_rnw),   65'(0));
    chk("rst_addr",  65'(cmd_addr),  65'(0));
    chk("rst_wdata", 65'(cmd_wdata), 65'(0));
    check_stats("rst");

    // Known two-command datagram, held until both are queued
    pay_w[0] = 32'h0000_0010;
    pay_w[1] = 32'hDEAD_BEEF;
    pay_w[2] = 32'h8000_0020;
    pay_w[3] = 32'h5A5A_1234;
    cmd_ready = 1'b0;
    send(vecs[0], 1'b1);
    chk("t1_head_addr", 65'(cmd_addr), 65'(31'h10));
    chk("t1_head_data", 65'(cmd_wdata), 65'(32'hDEADBEEF));
    drain();
    account(vecs[0]);
    check_stats("t1");

    for (int i = 0; i < 10; i++) begin
      fill_random();
      send(vecs[i], 1'b0);
      drain();
      account(vecs[i]);
      check_stats($sformatf("vec%0d", i));
    end

    // Overflow: six commands into a four-entry queue with the consumer stalled
    fill_random();
    v = '{8, 16'd56, 16'h1001, 48, 0, 4, 0, 1, 0};
    cmd_ready = 1'b0;
    send(v, 1'b0);
    account(v);
    exp_ovf += 2;
    check_stats("ovf");
    h = sbq[0];
    cycle();
    cycle();
    chk("ovf_head_stable", {cmd_last, cmd_rnw, cmd_addr, cmd_wdata}, h);
    chk("ovf_valid_held", 65'(cmd_valid), 65'(1));
    drain();

    // Reset at header byte 3; the rest of the burst must be ignored
    drive(8'h12);
    drive(8'h34);
    drive(8'h10);
    udp_rxd   = 8'h01;
    udp_rx_dv = 1'b1;
    reset     = 1'b1;
    cycle();
    reset      = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
    exp_ovf    = 0;
    chk("midrst_valid", 65'(cmd_valid), 65'(0));
    check_stats("midrst");
    drive(8'h00);
    drive(8'h18);
    drive(8'h00);
    drive(8'h00);
    for (int i = 0; i < 16; i++) drive(8'($urandom));
    udp_rx_dv = 1'b0;
    cycle();
    cycle();
    chk("midrst_tail_valid", 65'(cmd_valid), 65'(0));
    check_stats("midrst_tail");
    fill_random();
    send(vecs[0], 1'b0);
    drain();
    account(vecs[0]);
    check_stats("post_rst");

    // Destination port handling
    fill_random();
`ifdef DCS_CMD_PORT_FILTER_EN
    v = '{8, 16'd24, 16'h2000, 16, 0, 0, 0, 0, 0};
`else
    v = '{8, 16'd24, 16'h2000, 16, 0, 2, 1, 1, 0};
`endif
    send(v, 1'b0);
    drain();
    account(v);
    check_stats("port_foreign");
    fill_random();
    v = '{8, 16'd24, 16'h1001, 16, 0, 2, 1, 1, 0};
    send(v, 1'b0);
    drain();
    account(v);
    check_stats("port_listen");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
